// File: rtl/note_sequencer_if.sv
// Host/tone-generator side bundle of the melody sequencer: table write port,
// playback control, and the registered playback outputs.
interface note_sequencer_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [2:0] wr_note;
    logic [7:0] wr_dur;
    logic       start;
    logic       stop;
    logic [4:0] len;
    logic [2:0] note;
    logic       busy;
    logic       done;
    logic [3:0] step;

    modport master (
        output wr_en, wr_addr, wr_note, wr_dur, start, stop, len,
        input  note, busy, done, step
    );

    modport slave (
        input  wr_en, wr_addr, wr_note, wr_dur, start, stop, len,
        output note, busy, done, step
    );
endinterface

// File: rtl/note_sequencer.sv
// Steps through a 16-entry (note, duration) table and drives the tone generator's note code.
// Optional NOTE_GAP_EN inserts GAP_TICKS ticks of silence between consecutive entries.
module note_sequencer #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int GAP_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    note_sequencer_if.slave  bus
);
    localparam int P     = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(P - 1);
`ifdef NOTE_GAP_EN
    localparam int GAP_CYC = GAP_TICKS * P;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYC - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
`ifdef NOTE_GAP_EN
        , S_GAP = 2'd3
`endif
    } state_t;

    logic [10:0]      table_r [16];
    state_t           state_r;
    logic [2:0]       note_r;
    logic             busy_r;
    logic             done_r;
    logic [3:0]       step_r;
    logic [4:0]       len_r;
    logic [7:0]       dur_cnt_r;
    logic [PRE_W-1:0] pre_r;
`ifdef NOTE_GAP_EN
    logic [GAP_W-1:0] gap_r;
`endif

    logic [10:0] entry_s;
    logic        last_s;
    logic        len_ok_s;
    logic [3:0]  next_step_s;

    // Melody table write port; deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            table_r[bus.wr_addr] <= {bus.wr_note, bus.wr_dur};
        end
    end

    // Current entry read and end-of-melody / start-acceptance decode.
    always_comb begin
        entry_s     = table_r[step_r];
        last_s      = (({1'b0, step_r}) + 5'd1) == len_r;
        len_ok_s    = (bus.len != 5'd0) && (bus.len <= 5'd16);
        next_step_s = step_r + 4'd1;
    end

    // Playback FSM; step_r doubles as the entry index. Completion and advance
    // are resolved on the same edge that ends an entry, so there is no NEXT state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            note_r    <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            step_r    <= 4'd0;
            len_r     <= 5'd0;
            dur_cnt_r <= 8'd0;
            pre_r     <= '0;
`ifdef NOTE_GAP_EN
            gap_r     <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            if ((state_r != S_IDLE) && bus.stop) begin
                state_r <= S_IDLE;
                note_r  <= 3'd0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        note_r <= 3'd0;
                        if (bus.start && !bus.stop && len_ok_s) begin
                            len_r   <= bus.len;
                            step_r  <= 4'd0;
                            busy_r  <= 1'b1;
                            state_r <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (entry_s[7:0] == 8'd0) begin
                            if (last_s) begin
                                state_r <= S_IDLE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                step_r  <= next_step_s;
                            end
                        end else begin
                            note_r    <= entry_s[10:8];
                            dur_cnt_r <= entry_s[7:0];
                            pre_r     <= '0;
                            state_r   <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (pre_r == PRE_MAX) begin
                            pre_r <= '0;
                            if (dur_cnt_r == 8'd1) begin
                                note_r <= 3'd0;
                                if (last_s) begin
                                    state_r <= S_IDLE;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                end else begin
`ifdef NOTE_GAP_EN
                                    gap_r   <= '0;
                                    state_r <= S_GAP;
`else
                                    step_r  <= next_step_s;
                                    state_r <= S_LOAD;
`endif
                                end
                            end else begin
                                dur_cnt_r <= dur_cnt_r - 8'd1;
                            end
                        end else begin
                            pre_r <= pre_r + 1'b1;
                        end
                    end
`ifdef NOTE_GAP_EN
                    // Gap is only entered when another entry follows, so it always advances.
                    S_GAP: begin
                        note_r <= 3'd0;
                        if (gap_r == GAP_MAX) begin
                            step_r  <= next_step_s;
                            state_r <= S_LOAD;
                        end else begin
                            gap_r <= gap_r + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_r <= S_IDLE;
                        note_r  <= 3'd0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.note = note_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.step = step_r;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus random melodies
// compared cycle by cycle against a trace built from the melody rules.
module tb_note_sequencer;
    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 250;
    localparam int GAP_TICKS = 1;
    localparam int P         = CLK_HZ / TICK_HZ;

    logic clk = 1'b0;
    logic rst = 1'b1;

    note_sequencer_if bus ();

    note_sequencer #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2:0] m_note [16];
    logic [7:0] m_dur  [16];
    logic [8:0] exp_q  [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] rec(input int n, input int b, input int d, input int s);
        logic [2:0] n3;
        logic [3:0] s4;
        n3 = n[2:0];
        s4 = s[3:0];
        return {n3, b[0], d[0], s4};
    endfunction

    function automatic logic [8:0] obs();
        return {bus.note, bus.busy, bus.done, bus.step};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int n, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[3:0];
        bus.wr_note = n[2:0];
        bus.wr_dur  = d[7:0];
        cyc();
        bus.wr_en   = 1'b0;
        m_note[a]   = n[2:0];
        m_dur[a]    = d[7:0];
    endtask

    // Expected per-cycle outputs from the cycle after the accepted start onward.
    task automatic build_trace(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(rec(0, 1, 0, i));
            repeat (int'(m_dur[i]) * P) exp_q.push_back(rec(int'(m_note[i]), 1, 0, i));
`ifdef NOTE_GAP_EN
            if (m_dur[i] != 8'd0 && i != n - 1)
                repeat (GAP_TICKS * P) exp_q.push_back(rec(0, 1, 0, i));
`endif
        end
        exp_q.push_back(rec(0, 0, 1, n - 1));
        exp_q.push_back(rec(0, 0, 0, n - 1));
    endtask

    // Start a melody and compare every cycle; optionally poke start or a live write mid-play.
    task automatic play(input int n, input int start_at, input int wr_at, input string tag);
        build_trace(n);
        bus.len   = n[4:0];
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            check_eq(tag, {23'd0, obs()}, {23'd0, exp_q[j]});
            bus.start = (j == start_at);
            if (j == start_at) bus.len = 5'd1;
            if (j == wr_at) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 4'd0;
                bus.wr_note = 3'd5;
                bus.wr_dur  = 8'd1;
            end else begin
                bus.wr_en = 1'b0;
            end
            cyc();
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic load_basic();
        write_entry(0, 1, 2);
        write_entry(1, 3, 1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_note = 3'd0; bus.wr_dur = 8'd0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.len = 5'd0;
        rst = 1'b1;
        cyc(); cyc();
        check_eq("rst_note", {29'd0, bus.note}, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_step", {28'd0, bus.step}, 32'd0);
        rst = 1'b0;
        cyc();

        for (int a = 0; a < 16; a++) write_entry(a, 0, 0);
        load_basic();
        play(2, -1, -1, "basic");

        write_entry(0, 1, 1);
        write_entry(1, 2, 0);
        write_entry(2, 3, 1);
        play(3, -1, -1, "skip");

        load_basic();
        play(2, 3, -1, "start_busy");

        // Abort during the first note.
        bus.len = 5'd2; bus.start = 1'b1; cyc(); bus.start = 1'b0;
        repeat (4) cyc();
        check_eq("abort_pre", {28'd0, bus.note, bus.busy}, {28'd0, 3'd1, 1'b1});
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        check_eq("abort_out", {27'd0, bus.note, bus.busy, bus.done}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check_eq("abort_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        end

        // Ignored starts: bad lengths and start together with stop.
        bus.len = 5'd0; bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc();
        check_eq("len0", {31'd0, bus.busy}, 32'd0);
        bus.len = 5'd17; bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc();
        check_eq("len17", {31'd0, bus.busy}, 32'd0);
        bus.len = 5'd2; bus.start = 1'b1; bus.stop = 1'b1; cyc();
        bus.start = 1'b0; bus.stop = 1'b0; cyc();
        check_eq("start_stop", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset mid-play, table must survive.
        bus.len = 5'd2; bus.start = 1'b1; cyc(); bus.start = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        check_eq("midrst", {23'd0, obs()}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        play(2, -1, -1, "after_rst");

        play(2, -1, 2, "live_wr");
        m_note[0] = 3'd5;
        m_dur[0]  = 8'd1;
        play(2, -1, -1, "live_next");

        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 16; a++)
                write_entry(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            play(int'($urandom_range(1, 16)), -1, -1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a stored melody on the single-note tone generator by sequencing its 3-bit `note` input. Holds up to 16 programmable (note, duration) entries, written by the keyboard/host logic. On `start` it steps through the first `len` entries, holding each note for a duration counted in prescaled ticks. It sits between the key/host control logic and the tone generator; its `note` output drives the tone generator's `note` input directly.

## Interface
- `CLK_HZ`, 50000000, system clock frequency.
- `TICK_HZ`, 100, duration tick rate. P = CLK_HZ/TICK_HZ clock cycles per tick, integer division, P ≥ 2.
- `GAP_TICKS`, 2, silence ticks inserted between notes; used only with NOTE_GAP_EN, must be ≥ 1.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write strobe for the melody table.
- `wr_addr` in 4: table entry index, 0..15.
- `wr_note` in 3: note code; 0 = rest, 1..7 = A..G.
- `wr_dur` in 8: duration in ticks; 0 = skip entry.
- `start` in 1: begin playback; level-sampled.
- `stop` in 1: abort playback.
- `len` in 5: number of entries to play, 1..16; latched on accepted `start`.
- `note` out 3: note code to the tone generator; 0 = silent.
- `busy` out 1: high while playback is in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `step` out 4: index of the current entry.

## Operation
- Table: 16 × 11-bit entries (note, dur).
  - Written on any cycle with `wr_en`; the write takes effect at the edge.
  - Not cleared by `rst`.
  - A write to the entry currently playing does not alter the current note; it affects only later reads.
- Reset values: `note`=0, `busy`=0, `done`=0, `step`=0, state IDLE, prescaler and counters 0. `rst` mid-playback stops immediately, with no `done` pulse.
- States:
  - IDLE: `note`=0, `busy`=0. If `start`, `stop`=0 and `len`∈1..16: latch `len`, set idx=0, `busy`←1, go to LOAD. `start` with `len`=0 or `len`>16 is ignored.
  - LOAD, 1 cycle: `note`=0, `step`=idx. Read entry idx.
    - If dur=0: go to NEXT directly.
    - Otherwise: `note`←entry note, dur_cnt←dur, clear prescaler, go to PLAY.
  - PLAY: prescaler counts 0..P−1; each wrap is a tick and decrements dur_cnt. On the tick where dur_cnt=1: `note`←0, then go to GAP (NOTE_GAP_EN, not last entry) or NEXT.
  - GAP: `note`=0 for GAP_TICKS×P cycles, then NEXT.
  - NEXT is an evaluation within the same edge, not a separate state:
    - If idx+1 = len: go to IDLE, `busy`←0, `done`←1 for one cycle.
    - Otherwise: idx←idx+1, go to LOAD.
- `stop` in any non-IDLE state: at the next edge go to IDLE with `note`=0, `busy`=0, no `done`. `stop` has priority over `start` and over completion.
- `start` while `busy` is ignored. `len`, `start` and `stop` have no effect on an in-flight note except through `stop`.
- A rest entry (note 0, dur>0) produces silence for dur×P cycles and counts as a note.
- All outputs are registered.

## Timing
- `start` sampled at edge k:
  - `busy`=1 after edge k.
  - First LOAD cycle is k..k+1.
  - `note` is valid after edge k+1.
- Each played entry holds `note` for exactly dur×P cycles.
- Without gap: exactly 1 cycle of `note`=0 (LOAD) between consecutive played entries.
- Skipped entries (dur=0) cost 1 LOAD cycle each.
- `done` and `busy`=0 appear after the edge that ends the last note's final tick. `note`=0 from that same edge.

## Configuration
- `NOTE_GAP_EN`
  - Defined: GAP state is compiled in. Silence between consecutive played notes is GAP_TICKS×P+1 cycles. No gap is inserted after the last entry.
  - Undefined: the GAP state and its counter are absent, and GAP_TICKS is unused.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=250 (P=4).
- Reset: assert `rst` mid-PLAY → `note`=0, `busy`=0, `done`=0, `step`=0 immediately. Previously written table contents are still intact after release.
- Basic: table 0:(1,2), 1:(3,1); `len`=2; pulse `start` → `busy`=1, then `note`=0 for 1 cycle, `note`=1 for 8 cycles, `note`=0 for 1 cycle, `note`=3 for 4 cycles. Then `done`=1 for one cycle with `busy`=0 and `note`=0.
- Skip: table (1,1), (2,0), (3,1); `len`=3 → `note` 1 (4 cycles), 0 (2 cycles), 3 (4 cycles). `note`=2 never appears; `step` passes through 1.
- Abort and ignored starts:
  - `stop` during note 1 of the basic melody → next cycle `note`=0, `busy`=0, no `done`.
  - `start` with `len`=0 → `busy` stays 0.
  - `start` while `busy` → no restart.
- Gap: NOTE_GAP_EN, GAP_TICKS=1, basic melody → silence of 5 cycles between notes; `done` follows note 3 with no trailing gap.
- Live write: write entry 0 to (5,1) while entry 0 plays → current `note` stays 1 for the full 8 cycles. The next `start` plays `note`=5.
